cvtb_pkt_transmitter: RTL and testbench

//  Egress end of the convertible FIFO. After the CPU releases a stored packet, it reads
//  the words [tx_head..tx_tail] from the buffer read port in order and drives them onto
//  the out_data/out_ctrl/out_wr/out_rdy packet bus. It pulses tx_done after the last

---
 rtl/cvtb_pkt_transmitter_if.sv | 25 ++
 rtl/cvtb_pkt_transmitter.sv | 134 +++++++++++++
 tb/tb_cvtb_pkt_transmitter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cvtb_pkt_transmitter_if.sv
// Packet bus between the CVTB egress and the next pipeline module.
// The master drives words; the slave applies back-pressure with out_rdy.
interface cvtb_pkt_transmitter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] out_data;
    logic [CTRL_WIDTH-1:0] out_ctrl;
    logic                  out_wr;
    logic                  out_rdy;

    modport master (
        output out_data,
        output out_ctrl,
        output out_wr,
        input  out_rdy
    );

    modport slave (
        input  out_data,
        input  out_ctrl,
        input  out_wr,
        output out_rdy
    );
endinterface

// File: rtl/cvtb_pkt_transmitter.sv
// CVTB egress: streams buffer words head..tail onto the packet bus
// through a two-entry skid buffer, pulsing tx_done after the last word.
module cvtb_pkt_transmitter #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_start,
    input  logic [ADDR_WIDTH-1:0] tx_head,
    input  logic [ADDR_WIDTH-1:0] tx_tail,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic [CTRL_WIDTH-1:0] mem_ctrl,
    cvtb_pkt_transmitter_if.master pkt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] last_ptr;
    logic                  all_issued;

    logic                  in_flight;
    logic [DATA_WIDTH-1:0] skid_data [2];
    logic [CTRL_WIDTH-1:0] skid_ctrl [2];
    logic                  skid_wp;
    logic                  skid_rp;
    logic [1:0]            skid_cnt;

    logic [1:0]            avail;
    logic                  has_word;
    logic                  out_wr;
    logic                  push;
    logic                  pop;
    logic                  last_out;
    logic [DATA_WIDTH-1:0] head_data;
    logic [CTRL_WIDTH-1:0] head_ctrl;

    // The word returning from memory this cycle counts as available,
    // so an empty buffer forwards it straight to the bus.
    assign avail    = skid_cnt + {1'b0, in_flight};
    assign has_word = (state == SEND) && (avail != 2'd0);
    assign out_wr   = has_word && pkt.out_rdy;

    assign head_data = (skid_cnt != 2'd0) ? skid_data[skid_rp] : mem_data;
    assign head_ctrl = (skid_cnt != 2'd0) ? skid_ctrl[skid_rp] : mem_ctrl;

    assign pkt.out_wr   = out_wr;
    assign pkt.out_data = out_wr ? head_data : '0;
    assign pkt.out_ctrl = out_wr ? head_ctrl : '0;

    assign mem_rd   = (state == SEND) && !all_issued && (avail < 2'd2);
    assign mem_addr = mem_rd ? rd_ptr : '0;

    assign pop      = out_wr && (skid_cnt != 2'd0);
    assign push     = in_flight && !(out_wr && (skid_cnt == 2'd0));
    assign last_out = out_wr && all_issued && (avail == 2'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            last_ptr   <= '0;
            all_issued <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (tx_start) begin
                        state      <= SEND;
                        rd_ptr     <= tx_head;
                        last_ptr   <= tx_tail;
                        all_issued <= 1'b0;
                        tx_busy    <= 1'b1;
                    end
                end
                SEND: begin
                    if (mem_rd) begin
                        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                        if (rd_ptr == last_ptr) all_issued <= 1'b1;
                    end
                    if (last_out) begin
                        state   <= DONE;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    tx_done <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    tx_busy <= 1'b0;
                    tx_done <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_flight <= 1'b0;
            skid_wp   <= 1'b0;
            skid_rp   <= 1'b0;
            skid_cnt  <= 2'd0;
        end else begin
            in_flight <= mem_rd;
            if (push) begin
                skid_data[skid_wp] <= mem_data;
                skid_ctrl[skid_wp] <= mem_ctrl;
                skid_wp            <= ~skid_wp;
            end
            if (pop) skid_rp <= ~skid_rp;
            unique case ({push, pop})
                2'b10:   skid_cnt <= skid_cnt + 2'd1;
                2'b01:   skid_cnt <= skid_cnt - 2'd1;
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_cvtb_pkt_transmitter.sv
// Scoreboard bench for cvtb_pkt_transmitter: stimulus queues expected
// addresses and words, a negedge monitor pops and compares them.
module tb_cvtb_pkt_transmitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_start;
    logic [8:0]  tx_head;
    logic [8:0]  tx_tail;
    logic        tx_busy;
    logic        tx_done;
    logic        mem_rd;
    logic [8:0]  mem_addr;
    logic [63:0] mem_data;
    logic [7:0]  mem_ctrl;

    int checks   = 0;
    int failures = 0;
    int rd_total = 0;
    int wr_total = 0;

    logic [8:0]  addr_q [$];
    logic [63:0] exp_d  [$];
    logic [7:0]  exp_c  [$];

    cvtb_pkt_transmitter_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) pkt ();

    cvtb_pkt_transmitter dut (
        .clk      (clk),
        .reset    (reset),
        .tx_start (tx_start),
        .tx_head  (tx_head),
        .tx_tail  (tx_tail),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_ctrl (mem_ctrl),
        .pkt      (pkt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] wdata(input logic [8:0] a);
        return {16'hD00D, 7'd0, a, 23'd0, a ^ 9'h155};
    endfunction

    function automatic logic [7:0] wctrl(input logic [8:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    // Buffer memory: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_data <= wdata(mem_addr);
            mem_ctrl <= wctrl(mem_addr);
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    always @(negedge clk) begin
        if (mem_rd) begin
            rd_total++;
            if (addr_q.size() == 0) fail_now("unexpected_mem_rd");
            else chk("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
        end
        if (pkt.out_wr) begin
            wr_total++;
            chk("out_wr_needs_rdy", 64'(pkt.out_rdy), 64'd1);
            if (exp_d.size() == 0) begin
                fail_now("unexpected_out_wr");
            end else begin
                chk("out_data", pkt.out_data, exp_d.pop_front());
                chk("out_ctrl", 64'(pkt.out_ctrl), 64'(exp_c.pop_front()));
            end
        end else begin
            chk("idle_out_data", pkt.out_data, 64'd0);
            chk("idle_out_ctrl", 64'(pkt.out_ctrl), 64'd0);
        end
        if (rd_total - wr_total > 2) fail_now("reads_ahead_gt_2");
    end

    task automatic push_pkt(input logic [8:0] h, input logic [8:0] t);
        logic [8:0] a;
        a = h;
        forever begin
            addr_q.push_back(a);
            exp_d.push_back(wdata(a));
            exp_c.push_back(wctrl(a));
            if (a == t) break;
            a = a + 9'd1;
        end
    endtask

    task automatic pulse(input logic [8:0] h, input logic [8:0] t);
        @(posedge clk); #1;
        tx_start = 1'b1;
        tx_head  = h;
        tx_tail  = t;
        @(posedge clk); #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (tx_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, 64'(seen), 64'd1);
    endtask

    task automatic drained(input string name);
        repeat (3) @(negedge clk);
        chk(name, 64'(exp_d.size() + addr_q.size()), 64'd0);
        chk({name, "_busy"}, 64'(tx_busy), 64'd0);
    endtask

    task automatic new_test;
        rd_total = 0;
        wr_total = 0;
    endtask

    initial begin
        logic rdy_pat [12];
        rdy_pat = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1};
        reset       = 1'b1;
        tx_start    = 1'b0;
        tx_head     = '0;
        tx_tail     = '0;
        mem_data    = '0;
        mem_ctrl    = '0;
        pkt.out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(tx_busy), 64'd0);
        chk("rst_done", 64'(tx_done), 64'd0);
        chk("rst_mem_rd", 64'(mem_rd), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_out_wr", 64'(pkt.out_wr), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: cycle-exact timing, head=0 tail=3, out_rdy high
        new_test();
        push_pkt(9'd0, 9'd3);
        @(posedge clk); #1;
        tx_start = 1'b1;
        tx_head  = 9'd0;
        tx_tail  = 9'd3;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            tx_start = 1'b0;
            @(negedge clk);
            chk($sformatf("t1_busy_c%0d", k), 64'(tx_busy),
                64'(k >= 1 && k <= 5));
            chk($sformatf("t1_mem_rd_c%0d", k), 64'(mem_rd),
                64'(k >= 1 && k <= 4));
            chk($sformatf("t1_out_wr_c%0d", k), 64'(pkt.out_wr),
                64'(k >= 2 && k <= 5));
            chk($sformatf("t1_done_c%0d", k), 64'(tx_done), 64'(k == 6));
        end
        drained("t1_drained");

        // 2: out_rdy pattern 1,0,0,1,0,1,1...
        new_test();
        push_pkt(9'd0, 9'd3);
        @(posedge clk); #1;
        tx_start = 1'b1;
        tx_head  = 9'd0;
        tx_tail  = 9'd3;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            tx_start    = 1'b0;
            pkt.out_rdy = rdy_pat[i];
            @(negedge clk);
            if (tx_done) break;
        end
        pkt.out_rdy = 1'b1;
        chk("t2_words", 64'(wr_total), 64'd4);
        drained("t2_drained");

        // 3: address wrap 510 -> 1
        new_test();
        push_pkt(9'd510, 9'd1);
        pulse(9'd510, 9'd1);
        wait_done("t3_done", 20);
        chk("t3_words", 64'(wr_total), 64'd4);
        drained("t3_drained");

        // 4: single word
        new_test();
        push_pkt(9'd7, 9'd7);
        pulse(9'd7, 9'd7);
        wait_done("t4_done", 20);
        chk("t4_words", 64'(wr_total), 64'd1);
        drained("t4_drained");

        // 5: second start while busy is ignored
        new_test();
        push_pkt(9'd20, 9'd22);
        pulse(9'd20, 9'd22);
        pulse(9'd100, 9'd101);
        wait_done("t5_done", 20);
        drained("t5_drained");
        chk("t5_words", 64'(wr_total), 64'd3);

        // 6: reset on the 2nd word, then a clean packet
        new_test();
        push_pkt(9'd40, 9'd45);
        pulse(9'd40, 9'd45);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (wr_total >= 2) break;
        end
        chk("t6_second_word", 64'(wr_total), 64'd2);
        reset = 1'b1;
        addr_q.delete();
        exp_d.delete();
        exp_c.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t6_rst_out_wr", 64'(pkt.out_wr), 64'd0);
        chk("t6_rst_busy", 64'(tx_busy), 64'd0);
        chk("t6_rst_mem_rd", 64'(mem_rd), 64'd0);
        new_test();
        push_pkt(9'd60, 9'd63);
        pulse(9'd60, 9'd63);
        wait_done("t6_done", 20);
        chk("t6_words", 64'(wr_total), 64'd4);
        drained("t6_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
